fix_length_packets2bytes: RTL and testbench

- Packet-to-byte serializer, the transmit-side counterpart of the fixed-length bytes-to-packets framer.
- Accepts Avalon-ST 32-bit words framed into fixed-length packets, emits an Avalon-ST 8-bit byte stream MSB-first. Sits between a packet-oriented DSP/DMA stage and a byte-wide link/modulator.
- Byte-level startofpacket/endofpacket are regenerated on the first and last emitted byte of each packet.

---
 rtl/fix_length_packets2bytes_pkg.sv | 11 +
 rtl/fix_length_packets2bytes_if.sv | 28 ++
 rtl/fix_length_packets2bytes_word_shifter.sv | 70 +++++++
 rtl/fix_length_packets2bytes.sv | 84 ++++++++
 tb/tb_fix_length_packets2bytes.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fix_length_packets2bytes_pkg.sv
// Shared types and helpers for the fixed-length packet-to-byte serializer.
package flp2b_pkg;
  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} pkt_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Bytes carried by a word: a full word unless it ends the packet with padding.
  function automatic logic [2:0] nbytes(input logic eop, input logic [1:0] empty);
    nbytes = eop ? (3'(BYTES_PER_WORD) - {1'b0, empty}) : 3'(BYTES_PER_WORD);
  endfunction
endpackage

// File: rtl/fix_length_packets2bytes_if.sv
// Avalon-ST 32-bit word sink plus 8-bit byte source; slave is the serializer side.
interface fix_length_packets2bytes_if;
  logic [31:0] asi_in0_data;
  logic        asi_in0_valid;
  logic        asi_in0_ready;
  logic        asi_in0_startofpacket;
  logic        asi_in0_endofpacket;
  logic [1:0]  asi_in0_empty;
  logic [7:0]  aso_out0_data;
  logic        aso_out0_valid;
  logic        aso_out0_ready;
  logic        aso_out0_startofpacket;
  logic        aso_out0_endofpacket;

  modport slave (
    input  asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
           asi_in0_empty, aso_out0_ready,
    output asi_in0_ready, aso_out0_data, aso_out0_valid, aso_out0_startofpacket,
           aso_out0_endofpacket
  );

  modport master (
    output asi_in0_data, asi_in0_valid, asi_in0_startofpacket, asi_in0_endofpacket,
           asi_in0_empty, aso_out0_ready,
    input  asi_in0_ready, aso_out0_data, aso_out0_valid, aso_out0_startofpacket,
           aso_out0_endofpacket
  );
endinterface

// File: rtl/fix_length_packets2bytes_word_shifter.sv
// One-word holding register that walks its bytes out MSB-first.
module flp2b_word_shifter
  import flp2b_pkg::*;
(
  input  logic        clock_clk,
  input  logic        reset_reset,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic        load_sop,
  input  logic        load_eop,
  input  logic [1:0]  load_empty,
  input  logic        out_ready,
  output logic        busy,
  output logic        last_byte,
  output logic [7:0]  byte_data,
  output logic        byte_sop,
  output logic        byte_eop
);
  logic [31:0] hold_q, hold_d;
  logic [1:0]  idx_q, idx_d;
  logic [2:0]  nb_q, nb_d;
  logic        busy_q, busy_d;
  logic        sop_q, sop_d;
  logic        eop_q, eop_d;

  assign busy      = busy_q;
  assign last_byte = ({1'b0, idx_q} == (nb_q - 3'd1));
  // idx 0 selects [31:24]; inverting idx turns it into a byte lane number.
  assign byte_data = hold_q[{~idx_q, 3'b000} +: 8];
  assign byte_sop  = busy_q & sop_q & (idx_q == 2'd0);
  assign byte_eop  = busy_q & eop_q & last_byte;

  always_comb begin
    hold_d = hold_q;
    idx_d  = idx_q;
    nb_d   = nb_q;
    busy_d = busy_q;
    sop_d  = sop_q;
    eop_d  = eop_q;
    if (load) begin
      hold_d = load_data;
      idx_d  = 2'd0;
      nb_d   = nbytes(load_eop, load_empty);
      busy_d = 1'b1;
      sop_d  = load_sop;
      eop_d  = load_eop;
    end else if (busy_q && out_ready) begin
      if (last_byte) busy_d = 1'b0;
      else           idx_d  = idx_q + 2'd1;
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hold_q <= '0;
      idx_q  <= '0;
      nb_q   <= '0;
      busy_q <= 1'b0;
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      idx_q  <= idx_d;
      nb_q   <= nb_d;
      busy_q <= busy_d;
      sop_q  <= sop_d;
      eop_q  <= eop_d;
    end
  end
endmodule

// File: rtl/fix_length_packets2bytes.sv
// Packet-to-byte serializer: packet FSM, word counter, optional length checker.
// Define FLP2B_LENGTH_CHECK_EN to enable err_len reporting.
module fix_length_packets2bytes
  import flp2b_pkg::*;
#(
  parameter int PKT_WORDS = 64,
  parameter int CNT_W     = 13
) (
  input  logic                       clock_clk,
  input  logic                       reset_reset,
  fix_length_packets2bytes_if.slave  bus,
  output logic                       err_len
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             busy, last_byte, in_ready, accept, load;
  pkt_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on the final byte's transfer keeps the byte stream gap-free.
  assign in_ready          = !busy | (last_byte & bus.aso_out0_ready);
  assign bus.asi_in0_ready = in_ready;
  assign accept            = bus.asi_in0_valid & in_ready;
  // Words outside a packet (no SOP while IDLE) are swallowed.
  assign load              = accept & (bus.asi_in0_startofpacket | (state_q == IN_PKT));
  assign bus.aso_out0_valid = busy;

  flp2b_word_shifter u_shifter (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .load        (load),
    .load_data   (bus.asi_in0_data),
    .load_sop    (bus.asi_in0_startofpacket),
    .load_eop    (bus.asi_in0_endofpacket),
    .load_empty  (bus.asi_in0_empty),
    .out_ready   (bus.aso_out0_ready),
    .busy        (busy),
    .last_byte   (last_byte),
    .byte_data   (bus.aso_out0_data),
    .byte_sop    (bus.aso_out0_startofpacket),
    .byte_eop    (bus.aso_out0_endofpacket)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (bus.asi_in0_startofpacket) begin
        state_d = bus.asi_in0_endofpacket ? IDLE : IN_PKT;
        cnt_d   = CNT_W'(1);
      end else if (state_q == IN_PKT) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (bus.asi_in0_endofpacket) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FLP2B_LENGTH_CHECK_EN
  localparam logic [CNT_W-1:0] PKT_LEN = CNT_W'(PKT_WORDS);
  logic err_d, err_q;

  // cnt_d is the ordinal of the word being accepted this cycle.
  assign err_d = load & (bus.asi_in0_endofpacket ? (cnt_d != PKT_LEN) : (cnt_d == PKT_LEN));

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) err_q <= 1'b0;
    else             err_q <= err_d;
  end

  assign err_len = err_q;
`else
  assign err_len = 1'b0;
`endif
endmodule

// File: tb/tb_fix_length_packets2bytes.sv
// Self-checking bench: byte-queue reference model plus directed pins and random traffic.
module tb_fix_length_packets2bytes;
  localparam int PKT_WORDS = 64;
`ifdef FLP2B_LENGTH_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct packed {logic sop; logic eop; logic [7:0] d;} byte_t;
  typedef struct {int cyc; byte_t b;} log_t;

  logic clock_clk = 1'b0;
  logic reset_reset;
  logic err_len;

  fix_length_packets2bytes_if bus();

  fix_length_packets2bytes #(.PKT_WORDS(PKT_WORDS), .CNT_W(13)) dut (
    .clock_clk   (clock_clk),
    .reset_reset (reset_reset),
    .bus         (bus),
    .err_len     (err_len)
  );

  always #5 clock_clk = ~clock_clk;

  byte_t exp_q[$];
  log_t  log_q[$];
  int    checks = 0, errors = 0, cyc = 0, err_pulses = 0;
  int    wcnt = 0, rdy_mode = 0;
  bit    in_pkt = 1'b0, err_exp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: accepted words become a list of expected bytes.
  task automatic model_accept(input logic [31:0] d, input logic s, input logic e, input logic [1:0] em);
    bit counted;
    int n;
    byte_t b;
    counted = 1'b0;
    if (s) begin
      in_pkt = !e; wcnt = 1; counted = 1'b1;
    end else if (in_pkt) begin
      if (wcnt < 8191) wcnt++;
      if (e) in_pkt = 1'b0;
      counted = 1'b1;
    end
    if (counted) begin
      n = e ? 4 - int'(em) : 4;
      for (int i = 0; i < n; i++) begin
        b.sop = s && (i == 0);
        b.eop = e && (i == n - 1);
        b.d   = d[31 - 8*i -: 8];
        exp_q.push_back(b);
      end
      if (CHK) err_exp = e ? (wcnt != PKT_WORDS) : (wcnt == PKT_WORDS);
    end
  endtask

  always @(negedge clock_clk) begin
    bit   exp_rdy;
    log_t le;
    cyc++;
    if (reset_reset) begin
      exp_q.delete(); in_pkt = 1'b0; wcnt = 0; err_exp = 1'b0;
      chk("rst_valid", 32'(bus.aso_out0_valid), 0);
      chk("rst_data",  32'(bus.aso_out0_data), 0);
      chk("rst_sop",   32'(bus.aso_out0_startofpacket), 0);
      chk("rst_eop",   32'(bus.aso_out0_endofpacket), 0);
      chk("rst_err",   32'(err_len), 0);
      chk("rst_ready", 32'(bus.asi_in0_ready), 1);
    end else begin
      exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.aso_out0_ready);
      chk("valid", 32'(bus.aso_out0_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0)
        chk("byte", 32'({bus.aso_out0_startofpacket, bus.aso_out0_endofpacket, bus.aso_out0_data}),
            32'(exp_q[0]));
      chk("in_ready", 32'(bus.asi_in0_ready), 32'(exp_rdy));
      chk("err_len", 32'(err_len), 32'(err_exp));
      if (err_len) err_pulses++;
      err_exp = 1'b0;
      if (exp_q.size() != 0 && bus.aso_out0_ready) begin
        le.cyc = cyc;
        le.b   = {bus.aso_out0_startofpacket, bus.aso_out0_endofpacket, bus.aso_out0_data};
        log_q.push_back(le);
        void'(exp_q.pop_front());
      end
      if (bus.asi_in0_valid && exp_rdy)
        model_accept(bus.asi_in0_data, bus.asi_in0_startofpacket, bus.asi_in0_endofpacket,
                     bus.asi_in0_empty);
    end
  end

  initial begin
    forever begin
      @(posedge clock_clk); #1;
      if (rdy_mode == 0)      bus.aso_out0_ready = 1'b1;
      else if (rdy_mode == 1) bus.aso_out0_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send_word(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] em, input int gap);
    int n;
    repeat (gap) begin @(posedge clock_clk); #1; end
    bus.asi_in0_data = d; bus.asi_in0_startofpacket = s;
    bus.asi_in0_endofpacket = e; bus.asi_in0_empty = em;
    bus.asi_in0_valid = 1'b1;
    n = 0;
    do begin @(negedge clock_clk); n++; end while (!bus.asi_in0_ready && n < 200);
    if (!bus.asi_in0_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout act=ready0 exp=ready1 word=%h", d);
    end
    @(posedge clock_clk); #1;
    bus.asi_in0_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin @(negedge clock_clk); n++; end
    while ((exp_q.size() != 0 || bus.aso_out0_valid) && n < 2000);
    if (exp_q.size() != 0 || bus.aso_out0_valid) begin
      checks++; errors++;
      $display("FAIL drain_timeout act=%0d exp=0", exp_q.size());
    end
    @(posedge clock_clk); #1;
  endtask

  logic [9:0] basic_b [4] = '{10'h2A1, 10'h0B2, 10'h0C3, 10'h1D4};
  logic [9:0] bp_b    [4] = '{10'h211, 10'h022, 10'h033, 10'h144};

  initial begin
    int len;
    logic [1:0] em;
    bus.asi_in0_data = '0; bus.asi_in0_valid = 1'b0; bus.asi_in0_startofpacket = 1'b0;
    bus.asi_in0_endofpacket = 1'b0; bus.asi_in0_empty = '0; bus.aso_out0_ready = 1'b1;
    reset_reset = 1'b1;
    repeat (3) @(posedge clock_clk); #1;
    reset_reset = 1'b0;
    @(posedge clock_clk); #1;

    // basic byte order
    log_q.delete();
    send_word(32'hA1B2C3D4, 1, 1, 0, 0);
    wait_idle();
    chk("basic_n", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("basic_byte", 32'(log_q[i].b), 32'(basic_b[i]));
      chk("basic_span", 32'(log_q[3].cyc - log_q[0].cyc), 3);
    end

    // full-length packet, continuous
    log_q.delete(); err_pulses = 0;
    for (int k = 0; k < 64; k++) send_word(32'h00010203 + k, k == 0, k == 63, 0, 0);
    wait_idle();
    chk("full_n", 32'(log_q.size()), 256);
    if (log_q.size() == 256) begin
      chk("full_span", 32'(log_q[255].cyc - log_q[0].cyc), 255);
      chk("full_last", 32'(log_q[255].b), 32'h142);
      chk("full_first", 32'(log_q[0].b), 32'h200);
    end
    chk("full_err", 32'(err_pulses), 0);

    // backpressure 1,0,0,1
    rdy_mode = 2; bus.aso_out0_ready = 1'b1;
    log_q.delete();
    send_word(32'h11223344, 1, 1, 0, 0);
    @(posedge clock_clk); #1; bus.aso_out0_ready = 1'b0;
    @(posedge clock_clk); #1;
    @(posedge clock_clk); #1; bus.aso_out0_ready = 1'b1;
    rdy_mode = 0;
    wait_idle();
    chk("bp_n", 32'(log_q.size()), 4);
    if (log_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("bp_byte", 32'(bp_b[i]), 32'(log_q[i].b));
      chk("bp_stall", 32'(log_q[1].cyc - log_q[0].cyc), 3);
    end

    // empty=2 then immediate follow-on word
    log_q.delete();
    send_word(32'hDEADBEEF, 1, 1, 2, 0);
    send_word(32'h01020304, 1, 1, 0, 0);
    wait_idle();
    chk("empty_n", 32'(log_q.size()), 6);
    if (log_q.size() == 6) begin
      chk("empty_b0", 32'(log_q[0].b), 32'h2DE);
      chk("empty_b1", 32'(log_q[1].b), 32'h1AD);
      chk("empty_next", 32'(log_q[2].b), 32'h201);
      chk("empty_gap", 32'(log_q[2].cyc - log_q[1].cyc), 1);
    end

    // short packet length error, then words outside a packet
    err_pulses = 0;
    for (int k = 0; k < 10; k++) send_word(32'h5A000000 + k, k == 0, k == 9, 0, 0);
    wait_idle();
    repeat (2) @(negedge clock_clk);
    chk("err_pulses", 32'(err_pulses), CHK ? 1 : 0);
    log_q.delete();
    send_word(32'h55667788, 0, 1, 0, 0);
    send_word(32'h99AABBCC, 0, 0, 0, 0);
    repeat (6) @(negedge clock_clk);
    chk("drop_n", 32'(log_q.size()), 0);
    chk("drop_valid", 32'(bus.aso_out0_valid), 0);
    @(posedge clock_clk); #1;

    // reset in the middle of word 5
    for (int k = 0; k < 5; k++) send_word(32'h70707070 + k, k == 0, 0, 0, 0);
    @(posedge clock_clk); @(posedge clock_clk); #2;
    reset_reset = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.aso_out0_valid), 0);
    chk("mid_rst_data", 32'(bus.aso_out0_data), 0);
    repeat (2) @(posedge clock_clk); #1;
    reset_reset = 1'b0;
    @(posedge clock_clk); #1;
    log_q.delete();
    send_word(32'hCAFEBABE, 1, 0, 0, 0);
    send_word(32'h12345678, 0, 1, 0, 0);
    wait_idle();
    chk("post_rst_n", 32'(log_q.size()), 8);
    if (log_q.size() == 8) begin
      chk("post_rst_first", 32'(log_q[0].b), 32'h2CA);
      chk("post_rst_last", 32'(log_q[7].b), 32'h178);
    end

    // randomized traffic with strays, restarts and backpressure
    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      if (p % 7 == 3) send_word($urandom, 0, 1'($urandom_range(0, 1)), 0, $urandom_range(0, 2));
      len = (p == 20) ? PKT_WORDS : $urandom_range(1, 8);
      for (int k = 0; k < len; k++) begin
        em = 2'($urandom_range(0, 3));
        send_word($urandom, (k == 0) || (p % 5 == 2 && k == 1), k == len - 1, em,
                  $urandom_range(0, 2));
      end
    end
    rdy_mode = 0;
    wait_idle();
    chk("final_drain", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
